// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmit serializer (start, 8 data bits LSB first, optional even parity, stop)
// Ports:
//   clk_in        system clock, rising edge
//   rst_n_in      asynchronous active-low reset
//   baud_clk_in   divided clock level; each rising edge is one baud tick
//   tx_data_in    byte to send, latched on acceptance
//   tx_valid_in   byte available
//   tx_ready_out  high exactly in IDLE
//   tx_out        serial line, idles high
//   busy_out      frame in progress
//   done_out      one-cycle pulse when the last stop bit completes
// Configuration: define UART_TX_PARITY_EN to insert an even parity bit after the data bits.
module uart_tx_serializer #(
   parameter int TICKS_PER_BIT = 16,
   parameter int STOP_BITS     = 1
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       baud_clk_in,
   input  logic [7:0] tx_data_in,
   input  logic       tx_valid_in,
   output logic       tx_ready_out,
   output logic       tx_out,
   output logic       busy_out,
   output logic       done_out
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t     state_q, state_d;
   logic       baud_q;
   logic [7:0] tick_cnt_q, tick_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       tx_q, tx_d;
   logic       done_q, done_d;
   logic       tick, accept, period_end;
`ifdef UART_TX_PARITY_EN
   logic       par_q, par_d;
`endif

   assign tick       = baud_clk_in & ~baud_q;
   assign accept     = tx_valid_in & (state_q == IDLE);
   assign period_end = tick & (tick_cnt_q == 8'(TICKS_PER_BIT - 1));

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= IDLE;
         baud_q     <= 1'b0;
         tick_cnt_q <= 8'd0;
         shift_q    <= 8'd0;
         bit_cnt_q  <= 3'd0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_clk_in;
         tick_cnt_q <= tick_cnt_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q      <= par_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      // IDLE holds the counter at zero, so a tick coinciding with acceptance is not counted
      tick_cnt_d = (state_q == IDLE) ? 8'd0 : !tick ? tick_cnt_q : period_end ? 8'd0 : tick_cnt_q + 8'd1;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      tx_d       = tx_q;
      done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d      = par_q;
`endif
      case (state_q)
         IDLE: if (accept) begin
            state_d   = START;
            tx_d      = 1'b0;
            shift_d   = tx_data_in;
            bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            par_d     = ^tx_data_in;
`endif
         end
         START: if (period_end) begin
            state_d = DATA;
            tx_d    = shift_q[0];
         end
         DATA: if (period_end) begin
            shift_d   = shift_q >> 1;
            // wraps 7 -> 0, leaving bit_cnt ready to count stop periods
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_d = PARITY;
               tx_d    = par_q;
`else
               state_d = STOP;
               tx_d    = 1'b1;
`endif
            end else begin
               tx_d = shift_q[1];
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (period_end) begin
            state_d   = STOP;
            tx_d      = 1'b1;
            bit_cnt_d = 3'd0;
         end
`endif
         STOP: if (period_end) begin
            if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tx_ready_out = (state_q == IDLE);
   assign busy_out     = (state_q != IDLE);
   assign tx_out       = tx_q;
   assign done_out     = done_q;
endmodule
